// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: processes one bit per clock, LSB first,
// and reports carry/borrow and signed overflow at the end of each operation.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic s_bit;
    logic c_next;
    logic last_bit;

    assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
    assign c_next   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1; the +1 enters as carry-in.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    c_d     = sub;
                    sub_d   = sub;
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_d  = {s_bit, sh_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    // MSB step: c_q is carry into MSB, c_next is carry out.
                    res_d   = {s_bit, sh_q[WIDTH-1:1]};
                    cout_d  = c_next ^ sub_q;
                    ovf_d   = c_q ^ c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = res_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8): arithmetic corners,
// latency, start-ignore, async reset abort and back-to-back operation.
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one operation; edges counted from the sampling edge (=1).
    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic s,
                          input logic [7:0] er, input logic ec,
                          input logic eo);
        int n;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'd9);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int nbusy;
        int ndone;
        int last_t;
        int pulses;
        logic [7:0] exp_r;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0;
        op_a = 8'h00; op_b = 8'h00;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);

        run_op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub0507", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0);
        run_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);
        run_op("sub3333", 8'h33, 8'h33, 1'b1, 8'h00, 1'b0, 1'b0);
        run_op("add5a25", 8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0, 1'b0);

        // start pulsed mid-run must be ignored
        @(negedge clk);
        start = 1'b1; op_a = 8'h12; op_b = 8'h34; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nbusy = busy ? 1 : 0;
        n = 1;
        while (!done && n < 30) begin
            if (n == 3) begin
                start = 1'b1; op_a = 8'hF0; op_b = 8'h0F; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end
        start = 1'b0;
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_res", 32'(result), 32'h46);
        chk("ign_cout", 32'(cout), 32'd0);
        chk("ign_busy", 32'(nbusy), 32'd8);
        @(negedge clk);
        chk("ign_idle", 32'(busy), 32'd0);

        // async reset at run cycle 4 aborts with no done
        @(negedge clk);
        start = 1'b1; op_a = 8'hAA; op_b = 8'h11; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        run_op("add1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // start held high: three back-to-back operations
        @(negedge clk);
        start = 1'b1; op_a = 8'h01; op_b = 8'h02; sub = 1'b0;
        pulses = 0; last_t = 0; exp_r = 8'h30;
        for (int t = 1; t < 60 && pulses < 3; t++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (pulses > 1)
                    chk("b2b_gap", 32'(t - last_t), 32'd10);
                last_t = t;
                exp_r = (pulses == 1) ? 8'h03 :
                        (pulses == 2) ? 8'h07 : 8'h0B;
                chk("b2b_res", 32'(result), 32'(exp_r));
                if (pulses == 1) begin op_a = 8'h03; op_b = 8'h04; end
                if (pulses == 2) begin op_a = 8'h05; op_b = 8'h06; end
                if (pulses == 3) start = 1'b0;
                @(negedge clk);
                t++;
                chk("b2b_pulse", 32'(done), 32'd0);
            end
            chk("b2b_hold", 32'(result), 32'(exp_r));
        end
        start = 1'b0;
        chk("b2b_count", 32'(pulses), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
